// File: rtl/uart_hello_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_hello_tx_pkg
// Shared constants for the UART greeting transmitter: default bit period
// derived from the board clock and baud rate, greeting length and ROM
// contents, and the transmit FSM state encoding.
// -----------------------------------------------------------------------------
package uart_hello_tx_pkg;

    localparam int unsigned CLK_HZ               = 32'd50_000_000;
    localparam int unsigned BAUD_RATE            = 32'd115_200;
    // 50 MHz / 115200 = 434 (truncated)
    localparam int unsigned DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD_RATE;

    localparam int unsigned MSG_LEN   = 32'd7;
    localparam int unsigned MSG_IDX_W = 32'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Greeting ROM: "Hello\r\n"
    function automatic logic [7:0] greeting_byte(input logic [MSG_IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h48;
            3'd1:    b = 8'h65;
            3'd2:    b = 8'h6C;
            3'd3:    b = 8'h6C;
            3'd4:    b = 8'h6F;
            3'd5:    b = 8'h0D;
            3'd6:    b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_hello_tx_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Loadable down-counter that times one UART bit period. Loading sets the
// counter to CLKS_PER_BIT-1; it then counts down and parks at zero, where
// tick is asserted. The owner reloads it on every bit entry, so the counter
// can never wrap.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (used while the block is disabled)
//   load       : reload with CLKS_PER_BIT-1 (start of a new bit)
//   tick       : counter is zero, current bit period ends this cycle
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 32'd434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CLKS_PER_BIT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r;

    // Bit-period down-counter with clear, reload and hold-at-zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (clr) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/uart_hello_tx.sv
// -----------------------------------------------------------------------------
// uart_hello_tx
// 8N1 LSB-first UART transmitter driving one TT output pin. Sends the fixed
// greeting "Hello\r\n" on hello_req (priority) or single bytes taken from a
// valid/ready port. Greeting frames are sent back to back with no idle gap.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : design selected; low aborts and holds the block idle
//   hello_req  : request to send the greeting (pulse or level)
//   in_valid   : external byte available
//   in_data    : external byte
//   in_ready   : byte accepted this cycle when in_valid & in_ready (comb)
//   txd        : UART line, idle high (registered)
//   busy       : frame or greeting in progress (registered)
//   msg_done   : one-cycle pulse after the stop bit of the last greeting byte
// -----------------------------------------------------------------------------
module uart_hello_tx
    import uart_hello_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       hello_req,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       txd,
    output logic       busy,
    output logic       msg_done
);

    localparam logic [MSG_IDX_W-1:0] LAST_IDX = MSG_IDX_W'(MSG_LEN - 32'd1);

    tx_state_e             state_r;
    tx_state_e             next_state_s;
    logic [7:0]            shift_r;
    logic [7:0]            shift_s;
    logic [2:0]            bit_idx_r;
    logic [2:0]            bit_idx_s;
    logic [MSG_IDX_W-1:0]  msg_idx_r;
    logic [MSG_IDX_W-1:0]  msg_idx_s;
    logic                  msg_mode_r;
    logic                  msg_mode_s;
    logic                  txd_r;
    logic                  txd_s;
    logic                  busy_r;
    logic                  busy_s;
    logic                  msg_done_r;
    logic                  msg_done_s;
    logic                  tick_s;
    logic                  load_s;
    logic                  is_idle_s;
    logic                  accept_msg_s;
    logic                  accept_byte_s;
    logic                  more_bytes_s;

    assign is_idle_s     = (state_r == ST_IDLE);
    assign accept_msg_s  = is_idle_s & ena & hello_req;
    assign accept_byte_s = is_idle_s & ena & ~hello_req & in_valid;
    assign more_bytes_s  = msg_mode_r & (msg_idx_r != LAST_IDX);
    assign in_ready      = is_idle_s & ena & ~hello_req;

    // Every bit entry (acceptance or a bit boundary that stays busy) reloads the counter
    assign load_s = (next_state_s != ST_IDLE) & (is_idle_s | tick_s);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~ena),
        .load  (load_s),
        .tick  (tick_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; ena low forces IDLE from any state
    always_comb begin
        next_state_s = state_r;
        if (!ena) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hello_req || in_valid) begin
                        next_state_s = ST_START;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        next_state_s = ST_DATA;
                    end else begin
                        next_state_s = ST_START;
                    end
                end
                ST_DATA: begin
                    if (tick_s && (bit_idx_r == 3'd7)) begin
                        next_state_s = ST_STOP;
                    end else begin
                        next_state_s = ST_DATA;
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        next_state_s = more_bytes_s ? ST_START : ST_IDLE;
                    end else begin
                        next_state_s = ST_STOP;
                    end
                end
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // Datapath next values: shifter, bit index and greeting sequencer
    always_comb begin
        shift_s    = shift_r;
        bit_idx_s  = bit_idx_r;
        msg_idx_s  = msg_idx_r;
        msg_mode_s = msg_mode_r;
        if (!ena) begin
            bit_idx_s  = 3'd0;
            msg_idx_s  = {MSG_IDX_W{1'b0}};
            msg_mode_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_msg_s) begin
                        shift_s    = greeting_byte({MSG_IDX_W{1'b0}});
                        bit_idx_s  = 3'd0;
                        msg_idx_s  = {MSG_IDX_W{1'b0}};
                        msg_mode_s = 1'b1;
                    end else if (accept_byte_s) begin
                        shift_s    = in_data;
                        bit_idx_s  = 3'd0;
                        msg_mode_s = 1'b0;
                    end else begin
                        shift_s = shift_r;
                    end
                end
                ST_DATA: begin
                    // bit_idx wraps 7->0 on the last data bit, ready for the next frame
                    if (tick_s) begin
                        shift_s   = {1'b0, shift_r[7:1]};
                        bit_idx_s = bit_idx_r + 3'd1;
                    end else begin
                        shift_s = shift_r;
                    end
                end
                ST_STOP: begin
                    if (tick_s && more_bytes_s) begin
                        msg_idx_s = msg_idx_r + MSG_IDX_W'(1);
                        shift_s   = greeting_byte(msg_idx_r + MSG_IDX_W'(1));
                    end else begin
                        shift_s = shift_r;
                    end
                end
                default: shift_s = shift_r;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r    <= 8'h00;
            bit_idx_r  <= 3'd0;
            msg_idx_r  <= {MSG_IDX_W{1'b0}};
            msg_mode_r <= 1'b0;
        end else begin
            shift_r    <= shift_s;
            bit_idx_r  <= bit_idx_s;
            msg_idx_r  <= msg_idx_s;
            msg_mode_r <= msg_mode_s;
        end
    end

    // Output decode from the upcoming state so registered txd leads with the start bit
    always_comb begin
        case (next_state_s)
            ST_IDLE:  txd_s = 1'b1;
            ST_START: txd_s = 1'b0;
            ST_DATA:  txd_s = shift_s[0];
            ST_STOP:  txd_s = 1'b1;
            default:  txd_s = 1'b1;
        endcase
        busy_s     = (next_state_s != ST_IDLE);
        msg_done_s = ena & (state_r == ST_STOP) & tick_s & msg_mode_r & ~more_bytes_s;
    end

    // Output registers; line idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd_r      <= 1'b1;
            busy_r     <= 1'b0;
            msg_done_r <= 1'b0;
        end else begin
            txd_r      <= txd_s;
            busy_r     <= busy_s;
            msg_done_r <= msg_done_s;
        end
    end

    assign txd      = txd_r;
    assign busy     = busy_r;
    assign msg_done = msg_done_r;

endmodule

// File: tb/tb_uart_hello_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_hello_tx
// Self-checking bench for uart_hello_tx with CLKS_PER_BIT=4: table-driven
// per-cycle vectors for idle and single-byte frames, plus hand-written
// sequences for the greeting, priority, ena abort and async reset cases.
// -----------------------------------------------------------------------------
module tb_uart_hello_tx;

    localparam int CPB = 4;
    localparam int FL  = 10 * CPB;
    localparam int GL  = 7 * FL;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       hello_req;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       txd;
    logic       busy;
    logic       msg_done;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       ena;
        logic       hello_req;
        logic       in_valid;
        logic [7:0] in_data;
        logic       exp_rdy;
        logic       exp_txd;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    logic txd_log  [0:399];
    logic busy_log [0:399];
    logic done_log [0:399];
    logic rdy_log  [0:399];

    logic [7:0] exp_msg [0:6];

    always #5 clk = ~clk;

    uart_hello_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .hello_req (hello_req),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .txd       (txd),
        .busy      (busy),
        .msg_done  (msg_done)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // UART frame bit j (0=start, 1..8=data LSB first, 9=stop)
    function automatic logic frame_bit(input logic [7:0] d, input int j);
        if (j == 0) return 1'b0;
        else if (j <= 8) return d[j-1];
        else return 1'b1;
    endfunction

    task automatic add_vec(input logic e, input logic h, input logic v, input logic [7:0] d,
                           input logic r, input logic t, input logic b, input logic dn);
        vec_t x;
        x.ena = e; x.hello_req = h; x.in_valid = v; x.in_data = d;
        x.exp_rdy = r; x.exp_txd = t; x.exp_busy = b; x.exp_done = dn;
        vecs.push_back(x);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add_vec(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // One accepted byte: acceptance vector, 39 more frame cycles, then back to idle
    task automatic add_frame(input logic [7:0] d);
        add_vec(1'b1, 1'b0, 1'b1, d, 1'b1, frame_bit(d, 0), 1'b1, 1'b0);
        for (int i = 1; i < FL; i++) add_vec(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, frame_bit(d, i / CPB), 1'b1, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Drive inputs at a negedge, check in_ready, then check registered outputs after the edge
    task automatic apply_vec(input vec_t v, input int idx);
        ena = v.ena; hello_req = v.hello_req; in_valid = v.in_valid; in_data = v.in_data;
        #1;
        check1($sformatf("vec%0d_in_ready", idx), in_ready, v.exp_rdy);
        @(negedge clk);
        check1($sformatf("vec%0d_txd", idx), txd, v.exp_txd);
        check1($sformatf("vec%0d_busy", idx), busy, v.exp_busy);
        check1($sformatf("vec%0d_msg_done", idx), msg_done, v.exp_done);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);
        checki({tag, "_vectors"}, vecs.size(), 1 + 20 + (FL + 1) + 1 + 2 * (FL + 1) + 2 - 1);
    endtask

    // Log outputs after each of n edges; release hello_req after the first and
    // in_valid once a byte has been accepted
    task automatic capture(input int n);
        logic drop;
        drop = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hello_req = 1'b0;
            if (drop) begin
                in_valid = 1'b0;
                drop = 1'b0;
            end
            #1;
            txd_log[i] = txd; busy_log[i] = busy; done_log[i] = msg_done; rdy_log[i] = in_ready;
            if (in_valid && in_ready) drop = 1'b1;
        end
    endtask

    function automatic logic [7:0] decode_frame(input int base);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = txd_log[base + CPB + CPB * b + CPB / 2];
        return r;
    endfunction

    task automatic check_greeting(input string tag);
        int frame_err;
        int gaps;
        int first_done;
        int n_done;
        frame_err = 0; gaps = 0; first_done = -1; n_done = 0;
        for (int f = 0; f < 7; f++) begin
            check8($sformatf("%s_byte%0d", tag, f), decode_frame(f * FL), exp_msg[f]);
            if (txd_log[f * FL + CPB / 2] !== 1'b0) frame_err++;
            if (txd_log[f * FL + 9 * CPB + CPB / 2] !== 1'b1) frame_err++;
        end
        for (int i = 0; i < GL; i++) if (busy_log[i] !== 1'b1) gaps++;
        for (int i = 0; i < GL + 10; i++) begin
            if (done_log[i] === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = i;
            end
        end
        checki({tag, "_framing_errors"}, frame_err, 0);
        checki({tag, "_busy_gaps"}, gaps, 0);
        checki({tag, "_msg_done_cycle"}, first_done, GL);
        checki({tag, "_msg_done_count"}, n_done, 1);
        check1({tag, "_busy_after"}, busy_log[GL], 1'b0);
        check1({tag, "_txd_after"}, txd_log[GL], 1'b1);
    endtask

    initial begin
        int early;
        int bad_idle;
        exp_msg[0] = 8'h48; exp_msg[1] = 8'h65; exp_msg[2] = 8'h6C; exp_msg[3] = 8'h6C;
        exp_msg[4] = 8'h6F; exp_msg[5] = 8'h0D; exp_msg[6] = 8'h0A;

        rst_n = 1'b0; ena = 1'b0; hello_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check1("reset_txd", txd, 1'b1);
        check1("reset_busy", busy, 1'b0);
        check1("reset_in_ready", in_ready, 1'b0);
        check1("reset_msg_done", msg_done, 1'b0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        add_idle(20);
        add_frame(8'hA5);
        add_idle(1);
        add_frame(8'hFF);
        add_frame(8'h00);
        add_idle(2);
        run_table("t1");

        // Greeting from a one-cycle request
        hello_req = 1'b1;
        #1 check1("g1_req_in_ready", in_ready, 1'b0);
        capture(GL + 20);
        check_greeting("g1");

        // hello_req and in_valid together: greeting first, byte only after msg_done
        hello_req = 1'b1; in_valid = 1'b1; in_data = 8'h3C;
        #1 check1("g2_req_in_ready", in_ready, 1'b0);
        capture(GL + FL + 10);
        check_greeting("g2");
        early = 0;
        for (int i = 0; i < GL; i++) if (rdy_log[i] !== 1'b0) early++;
        checki("g2_early_ready", early, 0);
        check1("g2_ready_after_done", rdy_log[GL], 1'b1);
        check8("g2_byte_after", decode_frame(GL + 1), 8'h3C);
        check1("g2_busy_end", busy_log[GL + 1 + FL], 1'b0);

        // ena dropped in DATA of greeting byte 2 while txd is low
        hello_req = 1'b1;
        @(negedge clk);
        hello_req = 1'b0;
        repeat (2 * FL + CPB + 2) @(negedge clk);
        check1("abort_pre_txd", txd, 1'b0);
        check1("abort_pre_busy", busy, 1'b1);
        ena = 1'b0;
        @(negedge clk);
        check1("abort_txd", txd, 1'b1);
        check1("abort_busy", busy, 1'b0);
        check1("abort_msg_done", msg_done, 1'b0);
        bad_idle = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (msg_done !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) bad_idle++;
        end
        checki("abort_idle_hold", bad_idle, 0);
        ena = 1'b1; hello_req = 1'b1;
        #1 check1("g3_req_in_ready", in_ready, 1'b0);
        capture(GL + 20);
        check_greeting("g3");

        // Async reset in the middle of a byte frame
        in_valid = 1'b1; in_data = 8'hA5;
        #1 check1("rst_accept_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check1("rst_pre_txd", txd, frame_bit(8'hA5, 2));
        check1("rst_pre_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check1("rst_async_txd", txd, 1'b1);
        check1("rst_async_busy", busy, 1'b0);
        check1("rst_async_msg_done", msg_done, 1'b0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        run_table("t2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
